// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a length-prefixed little-endian
// byte stream into 32-bit words and holds the CPU until the image is in.
module imem_loader #(
  parameter int          IMEM_WORDS = 256,
  parameter logic [63:0] BASE_ADDR  = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [63:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA,
    S_WRITE, S_DONE, S_ERROR
  } state_e;

  localparam logic [16:0] MaxWords = 17'(IMEM_WORDS);

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] widx_q, widx_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [31:0] asm_q, asm_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] n_full;
  logic        xfer;

  assign xfer   = byte_valid && byte_ready;
  assign n_full = {byte_data, len_q[7:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      asm_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    asm_d   = asm_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = byte_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = byte_data;
          widx_d      = '0;
          bidx_d      = '0;
          if (n_full == 16'd0)
            state_d = S_DONE;
          else if ({1'b0, n_full} > MaxWords)
            state_d = S_ERROR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          asm_d[{bidx_q, 3'b000} +: 8] = byte_data;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            // Register the outputs now so they are stable for the strobe.
            addr_d  = BASE_ADDR + {46'd0, widx_q, 2'b00};
            wdata_d = {byte_data, asm_q[23:0]};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        widx_d  = widx_q + 16'd1;
        state_d = (widx_d == len_q) ? S_DONE : S_DATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign byte_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI)
                   || (state_q == S_DATA);
  assign busy       = byte_ready || (state_q == S_WRITE);
  assign imem_we    = (state_q == S_WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed scenarios plus randomized images,
// checked against a word-list model of the expected memory writes.
module tb_imem_loader;

  typedef struct {
    logic [63:0] a;
    logic [31:0] w;
  } wr_t;

  logic        clk, rst_n;
  logic        st0, bv0, st1, bv1;
  logic [7:0]  bd0, bd1;
  logic        br0, we0, hold0, busy0, done0, err0;
  logic        br1, we1, hold1, busy1, done1, err1;
  logic [63:0] ad0, ad1;
  logic [31:0] wd0, wd1;

  int checks = 0;
  int errors = 0;
  int rdyviol = 0;
  wr_t wq0[$];
  wr_t wq1[$];
  logic [31:0] mem0 [0:255];

  imem_loader u0 (
    .clk(clk), .reset_n(rst_n), .start(st0),
    .byte_valid(bv0), .byte_data(bd0), .byte_ready(br0),
    .imem_we(we0), .imem_addr(ad0), .imem_wdata(wd0),
    .cpu_hold(hold0), .busy(busy0), .done(done0), .error(err0)
  );

  imem_loader #(.IMEM_WORDS(4), .BASE_ADDR(64'h100)) u1 (
    .clk(clk), .reset_n(rst_n), .start(st1),
    .byte_valid(bv1), .byte_data(bd1), .byte_ready(br1),
    .imem_we(we1), .imem_addr(ad1), .imem_wdata(wd1),
    .cpu_hold(hold1), .busy(busy1), .done(done1), .error(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we0 === 1'b1) begin
      wq0.push_back('{ad0, wd0});
      mem0[ad0[9:2]] <= wd0;
      if (br0 !== 1'b0) rdyviol <= rdyviol + 1;
    end
    if (we1 === 1'b1) begin
      wq1.push_back('{ad1, wd1});
      if (br1 !== 1'b0) rdyviol <= rdyviol + 1;
    end
  end

  function automatic logic rdy(input int d);
    return (d == 0) ? br0 : br1;
  endfunction

  function automatic logic bsy(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction

  // {cpu_hold, busy, done, error}
  function automatic logic [3:0] stat(input int d);
    return (d == 0) ? {hold0, busy0, done0, err0}
                    : {hold1, busy1, done1, err1};
  endfunction

  function automatic int nwr(input int d);
    return (d == 0) ? wq0.size() : wq1.size();
  endfunction

  // Model: word i of the image must land at base + 4*i, in order.
  function automatic int first_bad(input int d,
                                   input logic [63:0] base,
                                   input logic [31:0] words[$]);
    wr_t q[$];
    q = (d == 0) ? wq0 : wq1;
    if (q.size() != words.size()) return -2;
    for (int i = 0; i < words.size(); i++) begin
      if (q[i].a !== base + 64'(4 * i)) return i;
      if (q[i].w !== words[i]) return i;
    end
    return -1;
  endfunction

  task automatic drive(input int d, input logic v, input logic [7:0] b);
    if (d == 0) begin bv0 = v; bd0 = b; end
    else begin bv1 = v; bd1 = b; end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(input int d);
    if (d == 0) st0 = 1'b1; else st1 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0; st1 = 1'b0;
  endtask

  task automatic send_byte(input int d, input logic [7:0] b);
    int n;
    n = 0;
    drive(d, 1'b1, b);
    forever begin
      @(negedge clk);
      if (rdy(d) === 1'b1) break;
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL send_byte_timeout dut=%0d byte=%h", d, b);
        break;
      end
    end
    @(posedge clk); #1;
    drive(d, 1'b0, 8'h00);
  endtask

  function automatic void build(input logic [15:0] n,
                                input logic [31:0] words[$],
                                output logic [7:0] s[$]);
    s = {};
    s.push_back(n[7:0]);
    s.push_back(n[15:8]);
    foreach (words[i])
      for (int k = 0; k < 4; k++) s.push_back(words[i][8*k +: 8]);
  endfunction

  // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps
  task automatic send_stream(input int d, input logic [7:0] s[$],
                             input int mode, input int gap_at,
                             input int gap_len);
    for (int i = 0; i < s.size(); i++) begin
      if (mode == 1) idle_cycles(1);
      if (mode == 2) idle_cycles($urandom_range(0, 2));
      if (i == gap_at) idle_cycles(gap_len);
      send_byte(d, s[i]);
    end
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (bsy(d) === 1'b1 && n < 200) begin
      idle_cycles(1);
      n++;
    end
    checks++;
    if (bsy(d) !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle dut=%0d busy still %b want 0", d, bsy(d));
    end
  endtask

  task automatic clear_log();
    wq0 = {};
    wq1 = {};
  endtask

  task automatic test_reset();
    logic [99:0] o;
    o = {br0, we0, ad0, wd0, hold0, busy0, done0, err0};
    checks++;
    if (o !== {2'b00, 64'h0, 32'h0, 4'b1000}) begin
      errors++;
      $display("FAIL reset_u0 got %h want %h", o,
               {2'b00, 64'h0, 32'h0, 4'b1000});
    end
    o = {br1, we1, ad1, wd1, hold1, busy1, done1, err1};
    checks++;
    if (o !== {2'b00, 64'h0, 32'h0, 4'b1000}) begin
      errors++;
      $display("FAIL reset_u1 got %h want %h", o,
               {2'b00, 64'h0, 32'h0, 4'b1000});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[$];
    logic [7:0]  s[$];
    int r;
    w = '{32'h00A00513, 32'h00100593};
    clear_log();
    rdyviol = 0;
    pulse_start(0);
    checks++;
    if (stat(0) !== 4'b1100) begin
      errors++;
      $display("FAIL b2b_after_start got %b want 1100", stat(0));
    end
    build(16'd2, w, s);
    send_stream(0, s, 0, -1, 0);
    wait_idle(0);
    r = first_bad(0, 64'h0, w);
    checks++;
    if (r !== -1) begin
      errors++;
      $display("FAIL b2b_writes got %0d want -1 (n=%0d)", r, nwr(0));
    end
    checks++;
    if (rdyviol !== 0) begin
      errors++;
      $display("FAIL b2b_ready_in_write got %0d want 0", rdyviol);
    end
    checks++;
    if (stat(0) !== 4'b0010) begin
      errors++;
      $display("FAIL b2b_final got %b want 0010", stat(0));
    end
  endtask

  task automatic test_gaps();
    logic [31:0] w[$];
    logic [7:0]  s[$];
    int r;
    w = '{32'h00A00513, 32'h00100593};
    clear_log();
    pulse_start(0);
    build(16'd2, w, s);
    send_stream(0, s, 1, 4, 20);
    wait_idle(0);
    r = first_bad(0, 64'h0, w);
    checks++;
    if (r !== -1) begin
      errors++;
      $display("FAIL gaps_writes got %0d want -1 (n=%0d)", r, nwr(0));
    end
    checks++;
    if (stat(0) !== 4'b0010) begin
      errors++;
      $display("FAIL gaps_final got %b want 0010", stat(0));
    end
  endtask

  task automatic test_error();
    logic [31:0] w[$];
    logic [7:0]  s[$];
    int r;
    clear_log();
    pulse_start(0);
    s = '{8'h01, 8'h01};
    send_stream(0, s, 0, -1, 0);
    idle_cycles(3);
    checks++;
    if ({stat(0), br0} !== 5'b10010 || nwr(0) !== 0) begin
      errors++;
      $display("FAIL err_overflow got %b n=%0d want 10010 n=0",
               {stat(0), br0}, nwr(0));
    end
    w = '{32'hDEADBEEF};
    pulse_start(0);
    build(16'd1, w, s);
    send_stream(0, s, 0, -1, 0);
    wait_idle(0);
    r = first_bad(0, 64'h0, w);
    checks++;
    if (r !== -1 || stat(0) !== 4'b0010) begin
      errors++;
      $display("FAIL err_retry got r=%0d st=%b want r=-1 st=0010",
               r, stat(0));
    end
  endtask

  task automatic test_zero_and_start_ignored();
    logic [31:0] w[$];
    logic [7:0]  s[$];
    int r;
    clear_log();
    pulse_start(0);
    s = '{8'h00, 8'h00};
    send_stream(0, s, 0, -1, 0);
    idle_cycles(2);
    checks++;
    if (stat(0) !== 4'b0010 || nwr(0) !== 0) begin
      errors++;
      $display("FAIL zero_len got st=%b n=%0d want 0010 n=0",
               stat(0), nwr(0));
    end
    w = '{32'h11223344, 32'hA5A55A5A};
    pulse_start(0);
    build(16'd2, w, s);
    for (int i = 0; i < 4; i++) send_byte(0, s[i]);
    pulse_start(0);
    for (int i = 4; i < s.size(); i++) send_byte(0, s[i]);
    wait_idle(0);
    r = first_bad(0, 64'h0, w);
    checks++;
    if (r !== -1 || stat(0) !== 4'b0010) begin
      errors++;
      $display("FAIL start_ignored got r=%0d st=%b want r=-1 st=0010",
               r, stat(0));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w[$];
    logic [7:0]  s[$];
    logic [99:0] o;
    int r;
    w = '{32'hCAFEF00D, 32'h0BADC0DE};
    clear_log();
    pulse_start(0);
    build(16'd2, w, s);
    for (int i = 0; i < 8; i++) send_byte(0, s[i]);
    #2 rst_n = 1'b0;
    #1;
    o = {br0, we0, ad0, wd0, hold0, busy0, done0, err0};
    checks++;
    if (o !== {2'b00, 64'h0, 32'h0, 4'b1000}) begin
      errors++;
      $display("FAIL midreset_outputs got %h want %h", o,
               {2'b00, 64'h0, 32'h0, 4'b1000});
    end
    checks++;
    if (nwr(0) !== 1 || mem0[0] !== w[0]) begin
      errors++;
      $display("FAIL midreset_mem got n=%0d m0=%h want n=1 m0=%h",
               nwr(0), mem0[0], w[0]);
    end
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(1);
    clear_log();
    w = '{32'h00000013, 32'h00008067};
    pulse_start(0);
    build(16'd2, w, s);
    send_stream(0, s, 2, -1, 0);
    wait_idle(0);
    r = first_bad(0, 64'h0, w);
    checks++;
    if (r !== -1 || stat(0) !== 4'b0010) begin
      errors++;
      $display("FAIL midreset_reload got r=%0d st=%b want r=-1 st=0010",
               r, stat(0));
    end
  endtask

  task automatic test_base_full();
    logic [31:0] w[$];
    logic [7:0]  s[$];
    int r;
    w = '{32'd1, 32'd2, 32'd3, 32'd4};
    clear_log();
    pulse_start(1);
    build(16'd4, w, s);
    send_stream(1, s, 0, -1, 0);
    wait_idle(1);
    r = first_bad(1, 64'h100, w);
    checks++;
    if (r !== -1 || stat(1) !== 4'b0010) begin
      errors++;
      $display("FAIL base_full got r=%0d n=%0d st=%b want r=-1 st=0010",
               r, nwr(1), stat(1));
    end
    clear_log();
    pulse_start(1);
    s = '{8'h05, 8'h00};
    send_stream(1, s, 0, -1, 0);
    idle_cycles(2);
    checks++;
    if (stat(1) !== 4'b1001 || nwr(1) !== 0) begin
      errors++;
      $display("FAIL base_over got st=%b n=%0d want 1001 n=0",
               stat(1), nwr(1));
    end
  endtask

  task automatic test_random();
    logic [31:0] w[$];
    logic [7:0]  s[$];
    int n, d, r;
    for (int t = 0; t < 6; t++) begin
      d = t % 2;
      n = (d == 0) ? $urandom_range(1, 8) : $urandom_range(1, 4);
      w = {};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      clear_log();
      pulse_start(d);
      build(16'(n), w, s);
      send_stream(d, s, 2, -1, 0);
      wait_idle(d);
      r = first_bad(d, (d == 0) ? 64'h0 : 64'h100, w);
      checks++;
      if (r !== -1 || stat(d) !== 4'b0010) begin
        errors++;
        $display("FAIL random_%0d got r=%0d st=%b want r=-1 st=0010",
                 t, r, stat(d));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    st0 = 1'b0; bv0 = 1'b0; bd0 = 8'h00;
    st1 = 1'b0; bv1 = 1'b0; bd1 = 8'h00;
    for (int i = 0; i < 256; i++) mem0[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    idle_cycles(2);
    test_back_to_back();
    test_gaps();
    test_error();
    test_zero_and_start_ignored();
    test_reset_mid();
    test_base_full();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: the single-cycle CPU only reads instruction memory, and this block fills it.
- Accepts a byte stream on a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word to consecutive instruction-memory word addresses and holds the CPU PC in reset until the program image is fully loaded.
- Sits between the external boot/debug byte source and the instruction memory write port and the pc reset input.

Parameters:
- IMEM_WORDS, 256, instruction-memory capacity in 32-bit words; maximum accepted image length.
- BASE_ADDR, 64'h0, byte address of the first instruction written.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load session.
- byte_valid  input  1  source has a byte on byte_data.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts byte this cycle; a transfer occurs when byte_valid && byte_ready.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  64  byte address of the word being written.
- imem_wdata  output  32  assembled instruction word.
- cpu_hold  output  1  drives the pc reset; 1 = PC held at reset.
- busy  output  1  a load session is in progress.
- done  output  1  sticky; image loaded successfully.
- error  output  1  sticky; declared length exceeds IMEM_WORDS.

Behaviour:
- Reset values: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, busy=0, done=0, error=0, FSM=IDLE, internal counters=0.
- Stream format:
  - Bytes 0-1: word count N, 16-bit little-endian.
  - Then 4*N instruction bytes, little-endian per word (first byte lands in bits [7:0]).
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR.
- IDLE: byte_ready=0. start -> LEN_LO. Clear done and error; set busy=1 and cpu_hold=1.
- LEN_LO: byte_ready=1. On transfer, latch N[7:0] -> LEN_HI.
- LEN_HI: byte_ready=1. On transfer, latch N[15:8], then:
  - N==0 -> DONE.
  - N>IMEM_WORDS -> ERROR.
  - Otherwise -> DATA, with word_idx=0 and byte_idx=0.
- DATA: byte_ready=1. Each transfer places byte_data at bits [8*byte_idx+7 : 8*byte_idx] of the assembly register and increments byte_idx (2 bits). The transfer with byte_idx==3 -> WRITE.
- WRITE: byte_ready=0. For exactly one cycle:
  - imem_we=1.
  - imem_wdata = assembled word.
  - imem_addr = BASE_ADDR + 4*word_idx (64-bit arithmetic, no wrap check needed since N<=IMEM_WORDS).
  - Then word_idx++; if the new word_idx==N -> DONE, else -> DATA.
- Latency and throughput: the write strobe comes 1 cycle after the 4th byte of a word is accepted; peak throughput is 4 bytes per 5 cycles.
- imem_addr/imem_wdata hold their last written values outside WRITE; only imem_we qualifies them.
- DONE: done=1, busy=0, cpu_hold=0 (CPU starts fetching at its reset PC on the next edge). byte_ready=0. start -> LEN_LO as from IDLE, re-asserting cpu_hold.
- ERROR: error=1, busy=0, cpu_hold stays 1, byte_ready=0, no memory writes. start -> LEN_LO (retry).
- start in LEN_LO/LEN_HI/DATA/WRITE: ignored.
- byte_valid with byte_ready=0: no transfer; the byte is not consumed and the source must hold it.
- Gaps (byte_valid=0) in any receiving state: stall with no timeout; state and partial word are preserved.
- Reset asserted mid-session: immediately returns all outputs to reset values. The partial word is discarded; words already written are not undone. cpu_hold=1.
- N==IMEM_WORDS is legal; the last address is BASE_ADDR+4*(IMEM_WORDS-1).

Test Plan:
1. Reset, start, then stream 02 00 | 13 05 A0 00 | 93 05 10 00 back-to-back valid.
   - Writes 32'h00A00513 @0 and 32'h00100593 @4, each imem_we exactly 1 cycle.
   - byte_ready low in the WRITE cycles.
   - done=1 and cpu_hold falls after the 2nd write.
2. Same image with byte_valid toggling every other cycle, plus a 20-cycle gap mid-word.
   - Identical writes and final state; no byte lost or duplicated.
3. Header 01 01 (N=257) with IMEM_WORDS=256.
   - error=1, cpu_hold=1, zero imem_we pulses.
   - A later start followed by a valid 1-word image clears error and sets done.
4. Header 00 00.
   - DONE directly, no writes, cpu_hold=0.
   - start asserted during a DATA phase of another session is ignored (session completes normally).
5. Assert reset_n=0 after 2 bytes of word 1 (word 0 already written).
   - All outputs immediately return to reset values; word 0 remains in memory.
   - A new start reloads from BASE_ADDR.
6. BASE_ADDR=64'h100, N=IMEM_WORDS=4, words 1..4.
   - Writes at 0x100, 0x104, 0x108, 0x10C.
   - done=1; exactly 4 imem_we pulses.
